// File: rtl/test_ctrl.sv
// test_ctrl: simulation-control responder on the core's data-memory bus.
// Firmware stores a pass/fail word to TOHOST. The block then drains the
// pipeline for a fixed number of cycles, freezes the core with halt, and
// reports done/pass/fail_code. It also provides free-running CYCLE and
// INSTRET counters and a watchdog that ends runaway programs.
//
// Bus handshake: mem_we / mem_re are per-cycle strobes qualified by sel.
// There is no ready. A store is taken at the rising edge where mem_we is
// high. A load is answered combinationally in the same cycle. rd_data shows
// the pre-write contents when both strobes are high together.
//
// ADDR_BASE must be 16-byte aligned. Only bits [31:4] take part in decode,
// and mem_addr[1:0] are ignored.
module test_ctrl #(
    parameter logic [31:0] ADDR_BASE      = 32'h0000_0FF0,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd52,
    parameter logic [2:0]  DRAIN_CYCLES   = 3'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_we,
    input  logic        mem_re,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        retire_valid,
    output logic        sel,
    output logic [31:0] rd_data,
    output logic        halt,
    output logic        done,
    output logic        pass,
    output logic [30:0] fail_code,
    output logic        timeout,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    // A drain length of 0 is treated as 1, so the load value never underflows.
    localparam logic [2:0] DRAIN_LOAD = (DRAIN_CYCLES == 3'd0) ? 3'd0 : (DRAIN_CYCLES - 3'd1);

    localparam logic [1:0] OFS_TOHOST  = 2'd0;
    localparam logic [1:0] OFS_CYCLE   = 2'd1;
    localparam logic [1:0] OFS_INSTRET = 2'd2;
    localparam logic [1:0] OFS_SCRATCH = 2'd3;

    state_t      state;
    logic [2:0]  drain_cnt;
    logic [31:0] tohost;
    logic [31:0] cycle_cnt;
    logic [31:0] instret_cnt;
    logic [31:0] scratch;

    logic        wr_sel;
    logic        tohost_go;
    logic        wd_fire;
    logic        counting;
    logic        unused_addr_bits;

    assign sel              = (mem_addr[31:4] == ADDR_BASE[31:4]);
    assign wr_sel           = sel && mem_we;
    assign unused_addr_bits = ^mem_addr[1:0];

    // Only the first nonzero TOHOST store of a run is accepted.
    assign tohost_go = wr_sel && (mem_addr[3:2] == OFS_TOHOST) && (state == ST_RUN)
                       && (mem_wdata != 32'd0);

    // The watchdog trips on the edge where CYCLE still holds TIMEOUT_CYCLES-1.
    assign wd_fire   = (TIMEOUT_CYCLES != 32'd0) && (state == ST_RUN)
                       && (cycle_cnt == (TIMEOUT_CYCLES - 32'd1));

    assign counting  = (state != ST_HALTED);
    assign dbg_state = state;

    // Run-control FSM. Status outputs are registered alongside the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_RUN;
            drain_cnt <= 3'd0;
            tohost    <= 32'd0;
            halt      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_code <= 31'd0;
            timeout   <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    // A TOHOST store wins over a watchdog trip in the same cycle.
                    if (tohost_go) begin
                        tohost    <= mem_wdata;
                        drain_cnt <= DRAIN_LOAD;
                        state     <= ST_DRAIN;
                    end else if (wd_fire) begin
                        state   <= ST_HALTED;
                        halt    <= 1'b1;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == 3'd0) begin
                        state <= ST_HALTED;
                        halt  <= 1'b1;
                        done  <= 1'b1;
                        if (tohost == 32'd1) begin
                            pass <= 1'b1;
                        end else begin
                            fail_code <= tohost[31:1];
                        end
                    end else begin
                        drain_cnt <= drain_cnt - 3'd1;
                    end
                end
                ST_HALTED: begin
                    // Terminal until reset.
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

    // Saturating cycle and retired-instruction counters, frozen once halted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_cnt   <= 32'd0;
            instret_cnt <= 32'd0;
        end else if (counting) begin
            if (cycle_cnt != 32'hFFFF_FFFF) begin
                cycle_cnt <= cycle_cnt + 32'd1;
            end
            if (retire_valid && (instret_cnt != 32'hFFFF_FFFF)) begin
                instret_cnt <= instret_cnt + 32'd1;
            end
        end
    end

    // SCRATCH is writable in every state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scratch <= 32'd0;
        end else if (wr_sel && (mem_addr[3:2] == OFS_SCRATCH)) begin
            scratch <= mem_wdata;
        end
    end

    // Combinational load mux. It reads register state, so a same-cycle store is not visible yet.
    always_comb begin
        rd_data = 32'd0;
        if (sel && mem_re) begin
            case (mem_addr[3:2])
                OFS_TOHOST:  rd_data = tohost;
                OFS_CYCLE:   rd_data = cycle_cnt;
                OFS_INSTRET: rd_data = instret_cnt;
                OFS_SCRATCH: rd_data = scratch;
                default:     rd_data = 32'd0;
            endcase
        end
    end

endmodule

// File: doc/test_ctrl.md
# test_ctrl

Memory-mapped simulation-control responder on the pipelined RISC-V core's data-memory bus. Firmware stores a pass/fail word to a TOHOST register. The block then drains the pipeline, asserts `halt`, and reports `done`/`pass`/`fail_code` so the bench can end the run. It also supplies cycle and retired-instruction counters, and a watchdog that ends runaway programs.

## Interface
- `ADDR_BASE`, 32'h0000_0FF0: base of the 16-byte register window; must be 16-byte aligned.
- `TIMEOUT_CYCLES`, 32'd52: watchdog limit in clock cycles; 0 disables the watchdog.
- `DRAIN_CYCLES`, 3'd4: cycles from TOHOST accept to `halt`, so in-flight stages can retire.

- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `mem_we` in 1: store strobe from the MEM stage.
- `mem_re` in 1: load strobe from the MEM stage.
- `mem_addr` in 32: byte address.
- `mem_wdata` in 32: store data.
- `retire_valid` in 1: one instruction retired (WB) this cycle.
- `sel` out 1: `mem_addr` lies in the window; combinational.
- `rd_data` out 32: load data; combinational.
- `halt` out 1: freeze the core pipeline.
- `done` out 1: run finished; sticky.
- `pass` out 1: finished with pass code.
- `fail_code` out 31: TOHOST[31:1] when failed.
- `timeout` out 1: finished by watchdog.

## Operation
- Window decode: `sel` = (`mem_addr[31:4]` == `ADDR_BASE[31:4]`). `mem_addr[1:0]` is ignored.
- Registers, by offset:
  - 0x0 TOHOST: write-once per run. Reads return the latched value.
  - 0x4 CYCLE: read-only. Writes are ignored.
  - 0x8 INSTRET: read-only. Writes are ignored.
  - 0xC SCRATCH: read/write, 32 bits.
- `rd_data` is 0 when `sel`=0 or `mem_re`=0.
- TOHOST semantics:
  - Value 1 means pass.
  - Any other nonzero value means fail; `fail_code` = value[31:1].
  - A value of 0 is ignored; the write does not change state.
- State machine, states RUN, DRAIN, HALTED:
  - RUN -> DRAIN on an accepted nonzero TOHOST write. Latch the value and load the drain counter with `DRAIN_CYCLES`-1.
  - RUN -> HALTED when CYCLE reaches `TIMEOUT_CYCLES`-1 and `TIMEOUT_CYCLES`≠0. Set `timeout`=1; `pass` stays 0.
  - DRAIN: the drain counter decrements each cycle; at 0, go to HALTED. `DRAIN_CYCLES`=0 behaves as 1.
  - HALTED is terminal until reset.
- `halt`=1 exactly in HALTED. `done`=1 in HALTED. `pass`/`fail_code` are valid when `done`=1 and are held afterwards.
- TOHOST writes in DRAIN or HALTED are ignored. SCRATCH remains writable in all states.
- CYCLE:
  - Increments every cycle in RUN and DRAIN; frozen in HALTED.
  - Saturates at 32'hFFFF_FFFF, with no wrap.
- INSTRET:
  - Increments on `retire_valid` in RUN and DRAIN; ignores `retire_valid` in HALTED.
  - Saturates at 32'hFFFF_FFFF.
- Simultaneous events:
  - A TOHOST write and the timeout condition in the same cycle: the TOHOST write wins and the block enters DRAIN.
  - `mem_we` and `mem_re` together: the read returns the pre-write value.
- Reset (any time, including mid-DRAIN): all registers, counters and outputs go to 0 and the state goes to RUN, immediately on `rst` low.

## Timing
- Reset values: `halt`=0, `done`=0, `pass`=0, `fail_code`=0, `timeout`=0, `rd_data`=0. CYCLE, INSTRET, TOHOST and SCRATCH are all 0.
- Write latency: register contents update at the edge on which `mem_we` is sampled. A read in the following cycle sees the new value.
- Read latency: 0 cycles; `rd_data` is combinational from the register state.
- TOHOST write accepted at edge N: state is DRAIN after edge N; `halt`/`done` assert after edge N+`DRAIN_CYCLES`.
- Timeout:
  - CYCLE holds k during the cycle following the k-th edge after reset release.
  - The watchdog fires at the edge where CYCLE = `TIMEOUT_CYCLES`-1.
  - `halt`/`done`/`timeout` are high from then on.
- Outputs are registered, except `sel` and `rd_data`.

## Test plan
- Reset release, idle 10 cycles, load 0xFF4 -> `rd_data`=10. All flags stay 0.
- Store 0x00000001 to 0xFF0 at cycle 20 -> `halt`=`done`=`pass`=1 from cycle 24. CYCLE frozen at 24; a further store of 0x7 to 0xFF0 is ignored.
- Store 0x0000000B to 0xFF0 -> `done`=1, `pass`=0, `fail_code`=5, `timeout`=0.
- No TOHOST write, `TIMEOUT_CYCLES`=52 -> `timeout`=`done`=`halt`=1 after edge 52. CYCLE reads 52. Also: a TOHOST write of 1 landing on edge 52 -> DRAIN, then `pass`=1 and `timeout`=0.
- `retire_valid` pulsed 7 times, 2 of them after `halt` -> INSTRET reads 5. SCRATCH write 0xDEADBEEF, then read 0xFFC -> 0xDEADBEEF. A load from 0x1000 -> `sel`=0 and `rd_data`=0.
- `rst` pulled low during DRAIN -> all outputs 0 at once. After release, a store of 1 to 0xFF0 restarts the sequence normally.
